// File: rtl/spd_decoder_pkg.sv
// Shared SPD decoder constants: byte offsets, DDR3 type code, CRC polynomial, FSM encodings.
package spd_decoder_pkg;

  localparam logic [7:0] SPD_DRAM_TYPE    = 8'd2;
  localparam logic [7:0] SPD_MODULE_TYPE  = 8'd3;
  localparam logic [7:0] SPD_DENSITY      = 8'd4;
  localparam logic [7:0] SPD_ADDRESSING   = 8'd5;
  localparam logic [7:0] SPD_ORGANIZATION = 8'd7;
  localparam logic [7:0] SPD_BUS_WIDTH    = 8'd8;
  localparam logic [7:0] SPD_MTB_DIVIDEND = 8'd10;
  localparam logic [7:0] SPD_MTB_DIVISOR  = 8'd11;
  localparam logic [7:0] SPD_TCK_MIN      = 8'd12;
  localparam logic [7:0] SPD_CRC_LSB      = 8'd126;
  localparam logic [7:0] SPD_CRC_MSB      = 8'd127;
  localparam logic [7:0] SPD_LAST_IDX     = 8'd127;

  localparam logic [7:0]  DDR3_TYPE_CODE = 8'h0B;
  localparam logic [15:0] CRC16_POLY     = 16'h1021;

  // Byte 0 bit 7 selects whether the CRC stops at byte 116 or byte 125.
  localparam logic [7:0] COVER_END_SHORT = 8'd116;
  localparam logic [7:0] COVER_END_LONG  = 8'd125;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRecv  = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StEnd   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/spd_decoder_if.sv
// Byte-stream handshake from the SPD read sequencer into the decoder.
interface spd_decoder_if;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_index;
  logic [7:0] byte_data;

  modport master (output byte_valid, output byte_index, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_index, input byte_data, output byte_ready);
endinterface

// File: rtl/spd_decoder_crc16_serial.sv
// Bit-serial CRC-16 engine: xor a byte into the top of the register, then 8 MSB-first shifts.
module spd_decoder_crc16_serial #(
  parameter logic [15:0] Poly = 16'h1021
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o,
  output logic        busy_o,
  output logic        last_o
);

  logic [15:0] crc_q, crc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  always_comb begin
    crc_d  = crc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (clear_i) begin
      crc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (load_i) begin
      crc_d  = crc_q ^ {data_i, 8'h00};
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      crc_d = crc_q[15] ? ({crc_q[14:0], 1'b0} ^ Poly) : {crc_q[14:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign crc_o  = crc_q;
  assign busy_o = busy_q;
  assign last_o = busy_q && (cnt_q == 3'd7);

endmodule

// File: rtl/spd_decoder.sv
// SPD byte-stream decoder: checks the CRC-16 over the covered range and latches DDR3 fields.
module spd_decoder
  import spd_decoder_pkg::*;
#(
  parameter logic [7:0]  LAST_BYTE = SPD_LAST_IDX,
  parameter logic [7:0]  DDR3_TYPE = DDR3_TYPE_CODE,
  parameter logic [15:0] CRC_POLY  = CRC16_POLY
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  spd_decoder_if.slave        byte_if,
  output logic [2:0]          o_ba_bits,
  output logic [3:0]          o_capacity,
  output logic [2:0]          o_row_bits,
  output logic [2:0]          o_col_bits,
  output logic [2:0]          o_ranks,
  output logic [2:0]          o_dev_width,
  output logic [2:0]          o_bus_width,
  output logic [7:0]          o_mtb_dividend,
  output logic [7:0]          o_mtb_divisor,
  output logic [7:0]          o_tck_min,
  output logic [3:0]          o_module_type,
  output logic                o_done,
  output logic                o_crc_ok,
  output logic                o_err_type,
  output logic                o_err_order
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  exp_idx_q, exp_idx_d, cover_end_q, cover_end_d;
  logic        last_q, last_d;
  logic [7:0]  b2_q, b2_d, mtb_dd_q, mtb_dd_d, mtb_dv_q, mtb_dv_d, tck_q, tck_d;
  logic [3:0]  b3_q, b3_d;
  logic [6:0]  b4_q, b4_d;
  logic [5:0]  b5_q, b5_d, b7_q, b7_d;
  logic [2:0]  b8_q, b8_d;
  logic [15:0] crc_ref_q, crc_ref_d;
  logic        done_q, done_d, crc_ok_q, crc_ok_d, err_type_q, err_type_d;
  logic        err_order_q, err_order_d;

  logic        crc_load, crc_busy, crc_last;
  logic [15:0] crc;
  logic [7:0]  idx, data;

  assign idx  = byte_if.byte_index;
  assign data = byte_if.byte_data;
  assign byte_if.byte_ready = (state_q == StRecv) && !crc_busy;

  spd_decoder_crc16_serial #(.Poly(CRC_POLY)) u_crc (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (i_start),
    .load_i  (crc_load),
    .data_i  (data),
    .crc_o   (crc),
    .busy_o  (crc_busy),
    .last_o  (crc_last)
  );

  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    cover_end_d = cover_end_q;
    last_d      = last_q;
    b2_d        = b2_q;
    b3_d        = b3_q;
    b4_d        = b4_q;
    b5_d        = b5_q;
    b7_d        = b7_q;
    b8_d        = b8_q;
    mtb_dd_d    = mtb_dd_q;
    mtb_dv_d    = mtb_dv_q;
    tck_d       = tck_q;
    crc_ref_d   = crc_ref_q;
    done_d      = done_q;
    crc_ok_d    = crc_ok_q;
    err_type_d  = err_type_q;
    err_order_d = err_order_q;
    crc_load    = 1'b0;

    // Restart from any state wins over a simultaneous accept.
    if (i_start) begin
      state_d     = StRecv;
      exp_idx_d   = '0;
      cover_end_d = COVER_END_LONG;
      last_d      = 1'b0;
      b2_d        = '0;
      b3_d        = '0;
      b4_d        = '0;
      b5_d        = '0;
      b7_d        = '0;
      b8_d        = '0;
      mtb_dd_d    = '0;
      mtb_dv_d    = '0;
      tck_d       = '0;
      crc_ref_d   = '0;
      done_d      = 1'b0;
      crc_ok_d    = 1'b0;
      err_type_d  = 1'b0;
      err_order_d = 1'b0;
    end else begin
      case (state_q)
        StRecv: begin
          if (byte_if.byte_valid && byte_if.byte_ready) begin
            if (idx != exp_idx_q) begin
              err_order_d = 1'b1;
              done_d      = 1'b1;
              state_d     = StDone;
            end else begin
              case (idx)
                SPD_DRAM_TYPE:    b2_d = data;
                SPD_MODULE_TYPE:  b3_d = data[3:0];
                SPD_DENSITY:      b4_d = data[6:0];
                SPD_ADDRESSING:   b5_d = data[5:0];
                SPD_ORGANIZATION: b7_d = data[5:0];
                SPD_BUS_WIDTH:    b8_d = data[2:0];
                SPD_MTB_DIVIDEND: mtb_dd_d = data;
                SPD_MTB_DIVISOR:  mtb_dv_d = data;
                SPD_TCK_MIN:      tck_d = data;
                SPD_CRC_LSB:      crc_ref_d[7:0] = data;
                SPD_CRC_MSB:      crc_ref_d[15:8] = data;
                default: ;
              endcase
              if (idx == 8'd0) cover_end_d = data[7] ? COVER_END_SHORT : COVER_END_LONG;
              if (exp_idx_q < LAST_BYTE) exp_idx_d = exp_idx_q + 8'd1;
              last_d = (idx == LAST_BYTE);
              if (idx <= cover_end_q) begin
                crc_load = 1'b1;
                state_d  = StShift;
              end else if (idx == LAST_BYTE) begin
                state_d = StEnd;
              end
            end
          end
        end
        StShift: if (crc_last) state_d = last_q ? StEnd : StRecv;
        StEnd: begin
          crc_ok_d   = (crc == crc_ref_q);
          err_type_d = (b2_q != DDR3_TYPE);
          done_d     = 1'b1;
          state_d    = StDone;
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      exp_idx_q   <= '0;
      cover_end_q <= COVER_END_LONG;
      last_q      <= 1'b0;
      b2_q        <= '0;
      b3_q        <= '0;
      b4_q        <= '0;
      b5_q        <= '0;
      b7_q        <= '0;
      b8_q        <= '0;
      mtb_dd_q    <= '0;
      mtb_dv_q    <= '0;
      tck_q       <= '0;
      crc_ref_q   <= '0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      err_type_q  <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      cover_end_q <= cover_end_d;
      last_q      <= last_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      b4_q        <= b4_d;
      b5_q        <= b5_d;
      b7_q        <= b7_d;
      b8_q        <= b8_d;
      mtb_dd_q    <= mtb_dd_d;
      mtb_dv_q    <= mtb_dv_d;
      tck_q       <= tck_d;
      crc_ref_q   <= crc_ref_d;
      done_q      <= done_d;
      crc_ok_q    <= crc_ok_d;
      err_type_q  <= err_type_d;
      err_order_q <= err_order_d;
    end
  end

  assign o_ba_bits      = b4_q[6:4];
  assign o_capacity     = b4_q[3:0];
  assign o_row_bits     = b5_q[5:3];
  assign o_col_bits     = b5_q[2:0];
  assign o_ranks        = b7_q[5:3];
  assign o_dev_width    = b7_q[2:0];
  assign o_bus_width    = b8_q;
  assign o_mtb_dividend = mtb_dd_q;
  assign o_mtb_divisor  = mtb_dv_q;
  assign o_tck_min      = tck_q;
  assign o_module_type  = b3_q;
  assign o_done         = done_q;
  assign o_crc_ok       = crc_ok_q;
  assign o_err_type     = err_type_q;
  assign o_err_order    = err_order_q;

endmodule
